// File: rtl/align_adder_stage_pipe.sv
// align_adder_stage_pipe
//   Align stage of the FP adder pipeline. Compares the biased exponents of z
//   and c and right-shifts the mantissa of the smaller operand up to the larger
//   exponent, folding every shifted-out bit into the sticky LSB. The aligned
//   beat is registered behind a valid/ready handshake that has a one-entry skid
//   register, so an upstream stall does not need a combinational ready path.
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready     upstream handshake (in_ready is !skid_valid)
//   idle_in                 1 = bypass, operands pass unaligned
//   opcode/tag/zpost/sout   sideband, copied through with the beat
//   z_in, c_in              {sign, biased exp, mantissa(LSB = sticky)}
//   out_valid / out_ready   downstream handshake
//   z_out, c_out, diff_out  aligned operands and the applied shift amount
module align_adder_stage_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 27,
  parameter int OP_W  = 4,
  parameter int TAG_W = 8,
  parameter int DAT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     idle_in,
  input  logic [OP_W-1:0]          opcode_in,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic [DAT_W-1:0]         zpost_in,
  input  logic [DAT_W-1:0]         sout_in,
  input  logic [EXP_W+MAN_W:0]     z_in,
  input  logic [EXP_W+MAN_W:0]     c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     idle_out,
  output logic [OP_W-1:0]          opcode_out,
  output logic [TAG_W-1:0]         tag_out,
  output logic [DAT_W-1:0]         zpost_out,
  output logic [DAT_W-1:0]         sout_out,
  output logic [EXP_W+MAN_W:0]     z_out,
  output logic [EXP_W+MAN_W:0]     c_out,
  output logic [EXP_W-1:0]         diff_out
);

  localparam int FW = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic             idle;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    logic [DAT_W-1:0] zpost;
    logic [DAT_W-1:0] sout;
    logic [FW-1:0]    z;
    logic [FW-1:0]    c;
    logic [EXP_W-1:0] diff;
  } beat_t;

  // Right shift with sticky. The mask covers the shifted-out bits; once d
  // reaches MAN_W the shift yields zero and the mask covers the whole
  // mantissa, so the large-shift case falls out as {0.., |m} without a
  // separate branch.
  function automatic logic [MAN_W-1:0] shr_sticky(input logic [MAN_W-1:0] m,
                                                  input logic [EXP_W-1:0] d);
    logic [MAN_W-1:0] mask;
    logic [MAN_W-1:0] r;
    mask = ~({MAN_W{1'b1}} << d);
    r    = m >> d;
    r[0] = r[0] | (|(m & mask));
    return r;
  endfunction

  logic             zs, cs;
  logic [EXP_W-1:0] ze, ce;
  logic [MAN_W-1:0] zm, cm;
  beat_t            nb;

  assign {zs, ze, zm} = z_in;
  assign {cs, ce, cm} = c_in;

  always_comb begin
    nb       = '0;
    nb.idle  = idle_in;
    nb.op    = opcode_in;
    nb.tag   = tag_in;
    nb.zpost = zpost_in;
    nb.sout  = sout_in;
    nb.z     = z_in;
    nb.c     = c_in;
    nb.diff  = '0;
    if (!idle_in) begin
      if (ze > ce) begin
        nb.diff = ze - ce;
        nb.c    = {cs, ze, shr_sticky(cm, ze - ce)};
      end else if (ce > ze) begin
        nb.diff = ce - ze;
        nb.z    = {zs, ce, shr_sticky(zm, ce - ze)};
      end
    end
  end

  // Output register (or_*) and skid register (sk_*). The skid only fills
  // while the output is held, and in_ready is low whenever it is full, so an
  // accept and a skid->output move never collide.
  logic  or_vld, sk_vld;
  beat_t or_q, sk_q;
  logic  acc, drain;

  assign in_ready = ~sk_vld;
  assign acc      = in_valid & in_ready;
  assign drain    = or_vld & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      or_vld <= 1'b0;
      sk_vld <= 1'b0;
      or_q   <= '0;
      sk_q   <= '0;
    end else if (!or_vld || drain) begin
      if (sk_vld) begin
        or_q   <= sk_q;
        or_vld <= 1'b1;
        sk_vld <= 1'b0;
      end else begin
        or_vld <= acc;
        if (acc) or_q <= nb;
      end
    end else if (acc) begin
      sk_q   <= nb;
      sk_vld <= 1'b1;
    end
  end

  assign out_valid  = or_vld;
  assign idle_out   = or_q.idle;
  assign opcode_out = or_q.op;
  assign tag_out    = or_q.tag;
  assign zpost_out  = or_q.zpost;
  assign sout_out   = or_q.sout;
  assign z_out      = or_q.z;
  assign c_out      = or_q.c;
  assign diff_out   = or_q.diff;

endmodule

// File: tb/tb_align_adder_stage_pipe.sv
module tb_align_adder_stage_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        idle_in = 1'b0;
  logic [3:0]  opcode_in = '0;
  logic [7:0]  tag_in = '0;
  logic [31:0] zpost_in = '0;
  logic [31:0] sout_in = '0;
  logic [35:0] z_in = '0;
  logic [35:0] c_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        idle_out;
  logic [3:0]  opcode_out;
  logic [7:0]  tag_out;
  logic [31:0] zpost_out;
  logic [31:0] sout_out;
  logic [35:0] z_out;
  logic [35:0] c_out;
  logic [7:0]  diff_out;

  int n_chk  = 0;
  int n_fail = 0;

  align_adder_stage_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .idle_in(idle_in), .opcode_in(opcode_in), .tag_in(tag_in),
    .zpost_in(zpost_in), .sout_in(sout_in), .z_in(z_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .idle_out(idle_out), .opcode_out(opcode_out), .tag_out(tag_out),
    .zpost_out(zpost_out), .sout_out(sout_out),
    .z_out(z_out), .c_out(c_out), .diff_out(diff_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic s, input logic [7:0] e, input logic [26:0] m);
    return {s, e, m};
  endfunction

  task automatic set_beat(input logic idle, input logic [7:0] tag,
                          input logic [35:0] z, input logic [35:0] c);
    idle_in   = idle;
    tag_in    = tag;
    opcode_in = tag[3:0];
    zpost_in  = {24'hA5A5A5, tag};
    sout_in   = {24'h5A5A5A, tag};
    z_in      = z;
    c_in      = c;
  endtask

  // One accepted beat with out_ready=1; leaves the result visible #1 after the edge.
  task automatic send(input logic idle, input logic [7:0] tag,
                      input logic [35:0] z, input logic [35:0] c);
    set_beat(idle, tag, z, c);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int got_n;
    int gaps;
    logic [7:0] rx [4];

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_z_out",     64'(z_out),     64'd0);
    chk("rst_diff",      64'(diff_out),  64'd0);
    reset = 1'b0;

    // shift with sticky
    send(1'b0, 8'h11, mk(1'b0, 8'h85, 27'h4000000), mk(1'b1, 8'h82, 27'h4000007));
    chk("sticky_valid", 64'(out_valid), 64'd1);
    chk("sticky_c",     64'(c_out),     64'(mk(1'b1, 8'h85, 27'h0800001)));
    chk("sticky_z",     64'(z_out),     64'(mk(1'b0, 8'h85, 27'h4000000)));
    chk("sticky_diff",  64'(diff_out),  64'd3);
    chk("sticky_op",    64'(opcode_out), 64'h1);
    chk("sticky_zpost", 64'(zpost_out), 64'hA5A5A511);
    chk("sticky_sout",  64'(sout_out),  64'h5A5A5A11);

    // large diff
    send(1'b0, 8'h12, mk(1'b0, 8'h90, 27'h0000010), mk(1'b0, 8'h70, 27'h1234567));
    chk("big_c",    64'(c_out),    64'(mk(1'b0, 8'h90, 27'h0000001)));
    chk("big_z",    64'(z_out),    64'(mk(1'b0, 8'h90, 27'h0000010)));
    chk("big_diff", 64'(diff_out), 64'h20);

    // mirror
    send(1'b0, 8'h13, mk(1'b0, 8'h80, 27'h0000003), mk(1'b0, 8'h81, 27'h1000000));
    chk("mir_z",    64'(z_out),    64'(mk(1'b0, 8'h81, 27'h0000001)));
    chk("mir_c",    64'(c_out),    64'(mk(1'b0, 8'h81, 27'h1000000)));
    chk("mir_diff", 64'(diff_out), 64'd1);

    // equal exponents
    send(1'b0, 8'h14, mk(1'b1, 8'h7F, 27'h2AAAAAA), mk(1'b0, 8'h7F, 27'h0000005));
    chk("eq_z",    64'(z_out),    64'(mk(1'b1, 8'h7F, 27'h2AAAAAA)));
    chk("eq_c",    64'(c_out),    64'(mk(1'b0, 8'h7F, 27'h0000005)));
    chk("eq_diff", 64'(diff_out), 64'd0);

    // idle bypass
    send(1'b1, 8'h15, mk(1'b0, 8'h90, 27'h0000013), mk(1'b1, 8'h70, 27'h1234567));
    chk("idle_z",    64'(z_out),    64'(mk(1'b0, 8'h90, 27'h0000013)));
    chk("idle_c",    64'(c_out),    64'(mk(1'b1, 8'h70, 27'h1234567)));
    chk("idle_flag", 64'(idle_out), 64'd1);
    chk("idle_diff", 64'(diff_out), 64'd0);
    chk("idle_tag",  64'(tag_out),  64'h15);

    // drain last beat
    @(posedge clock); #1;
    chk("drained_valid", 64'(out_valid), 64'd0);

    // backpressure: 3 stalled cycles, then stream out
    out_ready = 1'b0;
    set_beat(1'b0, 8'd1, mk(1'b0, 8'h81, 27'h5), mk(1'b0, 8'h80, 27'h3));
    in_valid = 1'b1;
    @(posedge clock); #1;
    chk("bp1_tag",   64'(tag_out),  64'd1);
    chk("bp1_ready", 64'(in_ready), 64'd1);
    set_beat(1'b0, 8'd2, mk(1'b0, 8'h81, 27'h5), mk(1'b0, 8'h80, 27'h3));
    @(posedge clock); #1;
    chk("bp2_ready", 64'(in_ready), 64'd0);
    chk("bp2_tag",   64'(tag_out),  64'd1);
    set_beat(1'b0, 8'd3, mk(1'b0, 8'h81, 27'h5), mk(1'b0, 8'h80, 27'h3));
    @(posedge clock); #1;
    chk("bp3_ready", 64'(in_ready), 64'd0);
    chk("bp3_tag",   64'(tag_out),  64'd1);
    chk("bp3_c",     64'(c_out),    64'(mk(1'b0, 8'h81, 27'h1)));
    out_ready = 1'b1;

    got_n = 0;
    gaps  = 0;
    for (int cyc = 0; cyc < 20 && got_n < 4; cyc++) begin
      logic fire_in;
      fire_in = in_valid & in_ready;
      if (out_valid) begin
        rx[got_n] = tag_out;
        got_n++;
      end else begin
        gaps++;
      end
      @(posedge clock); #1;
      if (fire_in) begin
        if (tag_in == 8'd4) in_valid = 1'b0;
        else set_beat(1'b0, tag_in + 8'd1, mk(1'b0, 8'h81, 27'h5), mk(1'b0, 8'h80, 27'h3));
      end
    end
    chk("bp_count", 64'(got_n), 64'd4);
    chk("bp_gaps",  64'(gaps),  64'd0);
    for (int i = 0; i < got_n; i++) chk("bp_order", 64'(rx[i]), 64'(i + 1));
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("bp_empty", 64'(out_valid), 64'd0);

    // reset mid-operation with OR and SK full
    out_ready = 1'b0;
    set_beat(1'b0, 8'h21, mk(1'b0, 8'h85, 27'h4000000), mk(1'b1, 8'h82, 27'h4000007));
    in_valid = 1'b1;
    @(posedge clock); #1;
    set_beat(1'b0, 8'h22, mk(1'b0, 8'h85, 27'h4000000), mk(1'b1, 8'h82, 27'h4000007));
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_ready", 64'(in_ready),  64'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_tag",   64'(tag_out),   64'd0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    send(1'b0, 8'h31, mk(1'b0, 8'h90, 27'h0000010), mk(1'b0, 8'h70, 27'h1234567));
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_tag",   64'(tag_out),   64'h31);
    chk("post_rst_c",     64'(c_out),     64'(mk(1'b0, 8'h90, 27'h0000001)));
    chk("post_rst_diff",  64'(diff_out),  64'h20);
    @(posedge clock); #1;
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
